// File: rtl/controle_farol.sv
// controle_farol: headlight-left-on alert with debounce, beep pattern, silence and auto-off request
module controle_farol #(
  parameter int DEB_CICLOS = 4,
  parameter int BIP_ON     = 8,
  parameter int BIP_OFF    = 8,
  parameter int MAX_BIPS   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       farol,
  input  logic       porta,
  input  logic       chave,
  input  logic       silenciar,
  output logic       sinalizador,
  output logic       buzzer,
  output logic       farol_off,
  output logic [2:0] estado,
  output logic [7:0] bips
);
  localparam int DW = $clog2(DEB_CICLOS + 1);
  typedef enum logic [2:0] {
    INATIVO    = 3'd0,
    ALERTA_ON  = 3'd1,
    ALERTA_OFF = 3'd2,
    SILENCIO   = 3'd3,
    DESLIGA    = 3'd4
  } state_t;
  state_t        st;
  logic          cond_raw;
  logic [DW-1:0] deb;
  logic [15:0]   timer;
  assign sinalizador = deb == DW'(DEB_CICLOS);
  assign estado = st;
  always_ff @(posedge clock) begin
    if (reset) begin
      cond_raw  <= 1'b0;
      deb       <= '0;
      timer     <= '0;
      bips      <= '0;
      st        <= INATIVO;
      buzzer    <= 1'b0;
      farol_off <= 1'b0;
    end else begin
      cond_raw  <= farol & ~(porta & chave);
      deb       <= !cond_raw ? '0 : sinalizador ? deb : deb + DW'(1);
      buzzer    <= 1'b0;
      farol_off <= 1'b0;
      timer     <= timer + 16'd1;
      case (st)
        INATIVO: if (sinalizador) begin
          st     <= ALERTA_ON;
          timer  <= '0;
          bips   <= '0;
          buzzer <= 1'b1;
        end
        ALERTA_ON, ALERTA_OFF: begin
          if (!sinalizador) begin
            st    <= INATIVO;
            timer <= '0;
            bips  <= '0;
          end else if (silenciar) begin
            st    <= SILENCIO;
            timer <= '0;
          end else if (st == ALERTA_ON) begin
            if (timer == 16'(BIP_ON - 1)) begin
              st    <= ALERTA_OFF;
              timer <= '0;
            end else
              buzzer <= 1'b1;
          end else if (timer == 16'(BIP_OFF - 1)) begin
            timer <= '0;
            bips  <= bips + 8'd1;
            // the beep just completed is the last one allowed: request headlight off
            if (bips + 8'd1 == 8'(MAX_BIPS)) begin
              st        <= DESLIGA;
              farol_off <= 1'b1;
            end else begin
              st     <= ALERTA_ON;
              buzzer <= 1'b1;
            end
          end
        end
        DESLIGA: begin
          st    <= SILENCIO;
          timer <= '0;
        end
        SILENCIO: if (!sinalizador) begin
          st    <= INATIVO;
          timer <= '0;
          bips  <= '0;
        end
        default: begin
          st    <= INATIVO;
          timer <= '0;
          bips  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controle_farol.sv
// tb_controle_farol: scoreboard bench with an episode-level reference model of the alert
module tb_controle_farol;
  localparam int DEB = 4, BON = 8, BOFF = 8, MAXB = 5, P = BON + BOFF;
  logic clk = 0, rst = 1, farol = 0, porta = 0, chave = 0, silenciar = 0;
  logic sinalizador, buzzer, farol_off;
  logic [2:0] estado;
  logic [7:0] bips;
  typedef struct {logic sin, buz, off; logic [2:0] est; logic [7:0] bp;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int mode = 0, t = 0, sb = 0;
  bit ok = 0;
  bit hist[$];
  controle_farol #(.DEB_CICLOS(DEB), .BIP_ON(BON), .BIP_OFF(BOFF), .MAX_BIPS(MAXB)) dut (
    .clock(clk), .reset(rst), .farol(farol), .porta(porta), .chave(chave),
    .silenciar(silenciar), .sinalizador(sinalizador), .buzzer(buzzer),
    .farol_off(farol_off), .estado(estado), .bips(bips)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  // monitor: every cycle the DUT presents a full output set, compared against the queued expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sinalizador", int'(sinalizador), int'(e.sin));
      chk("buzzer", int'(buzzer), int'(e.buz));
      chk("farol_off", int'(farol_off), int'(e.off));
      chk("estado", int'(estado), int'(e.est));
      chk("bips", int'(bips), int'(e.bp));
    end
  end
  // model: mode 0 idle, 1 alerting (t = cycles since first buzzer-high), 2 off pulse, 3 silenced
  task automatic step(input bit r, input bit f, input bit p, input bit c, input bit s);
    exp_t e;
    @(negedge clk);
    rst = r; farol = f; porta = p; chave = c; silenciar = s;
    if (r) begin
      mode = 0; t = 0; sb = 0; ok = 0;
      hist = {};
      repeat (DEB) hist.push_back(1'b0);
    end else begin
      case (mode)
        0: if (ok) begin mode = 1; t = 0; end
        1: if (!ok) begin mode = 0; sb = 0; end
           else if (s) begin mode = 3; sb = t / P; end
           else begin
             t++;
             if (t == MAXB * P) begin mode = 2; sb = MAXB; end
           end
        2: mode = 3;
        3: if (!ok) begin mode = 0; sb = 0; end
        default: mode = 0;
      endcase
      ok = 1;
      foreach (hist[i]) ok &= hist[i];
      hist.push_back(f & !(p & c));
      void'(hist.pop_front());
    end
    e.sin = ok;
    e.buz = mode == 1 && (t % P) < BON;
    e.off = mode == 2;
    e.est = mode == 0 ? 3'd0 : mode == 1 ? ((t % P) < BON ? 3'd1 : 3'd2) : mode == 2 ? 3'd4 : 3'd3;
    e.bp = mode == 1 ? 8'(t / P) : mode == 0 ? 8'd0 : 8'(sb);
    q.push_back(e);
  endtask
  task automatic hold(input int n, input bit f, input bit p, input bit c);
    repeat (n) step(0, f, p, c, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    hold(100, 1, 1, 1);
    hold(100, 1, 0, 1);
    hold(6, 0, 0, 0);
    hold(3, 1, 1, 0);
    hold(8, 0, 0, 0);
    for (int j = 0; j < 40; j++) step(0, 1, 0, 1, j == 24);
    hold(10, 0, 0, 0);
    for (int j = 0; j < 100; j++) step(0, 1, 0, 1, j == 84);
    hold(10, 0, 0, 0);
    for (int j = 0; j < 40; j++) step(j == 8, 1, 0, 1, 0);
    hold(10, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      bit f, p, c;
      int n;
      f = 1'($urandom); p = 1'($urandom); c = 1'($urandom);
      n = $urandom_range(1, 120);
      repeat (n) step($urandom_range(0, 500) == 0, f, p, c, $urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
